// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pipeline stages: sample format, FSM
// encoding and small elaboration-time helpers.
package cnn_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int pooled_dim(input int n);
        return n / 2;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// One row of partial 2x2 maxima: register array, synchronous write,
// combinational read.
module pool_row_buffer #(
    parameter int DEPTH      = 31,
    parameter int DATA_WIDTH = 16,
    parameter int IW         = 5
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic        [IW-1:0]         widx_i,
    input  logic signed [DATA_WIDTH-1:0] wdata_i,
    input  logic        [IW-1:0]         ridx_i,
    output logic signed [DATA_WIDTH-1:0] rdata_o
);

    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/maxpool2d.sv
// 2x2 stride-2 max pooling over a raster sample stream with optional ReLU,
// keeping only one row of partial maxima.
module maxpool2d #(
    parameter int IN_WIDTH   = 62,
    parameter int IN_HEIGHT  = 62,
    parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
    parameter int APPLY_RELU = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic signed [DATA_WIDTH-1:0] pool_data,
    output logic [cnn_pkg::width_of(cnn_pkg::pooled_dim(IN_WIDTH) *
                                    cnn_pkg::pooled_dim(IN_HEIGHT))-1:0] pool_addr,
    output logic                         pool_valid,
    output logic                         pool_done,
    output logic                         busy
);

    import cnn_pkg::*;

    localparam int OUT_W = pooled_dim(IN_WIDTH);
    localparam int OUT_H = pooled_dim(IN_HEIGHT);
    localparam int AW    = width_of(OUT_W * OUT_H);
    localparam int CW    = width_of(IN_WIDTH);
    localparam int RW    = width_of(IN_HEIGHT);
    localparam int BW    = width_of(OUT_W);

    localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);
    localparam bit            ODD_W    = (IN_WIDTH % 2) != 0;
    localparam bit            ODD_H    = (IN_HEIGHT % 2) != 0;

    state_e                       state_q, state_d;
    logic        [CW-1:0]         col_q, col_d;
    logic        [RW-1:0]         row_q, row_d;
    logic signed [DATA_WIDTH-1:0] hold_q, hold_d;
    logic signed [DATA_WIDTH-1:0] pool_data_q, pool_data_d;
    logic        [AW-1:0]         pool_addr_q, pool_addr_d;
    logic        [AW-1:0]         out_cnt_q, out_cnt_d;
    logic                         pool_valid_q, pool_valid_d;
    logic                         pool_done_q, pool_done_d;

    logic signed [DATA_WIDTH-1:0] x;
    logic signed [DATA_WIDTH-1:0] pair_max;
    logic signed [DATA_WIDTH-1:0] win_max;
    logic signed [DATA_WIDTH-1:0] rb_rdata;
    logic        [BW-1:0]         rb_idx;
    logic                         rb_we;
    logic                         at_col_last;
    logic                         at_row_last;
    logic                         discard;

    assign x           = (APPLY_RELU != 0 && in_data[DATA_WIDTH-1]) ? '0 : in_data;
    assign pair_max    = (hold_q > x) ? hold_q : x;
    assign win_max     = (rb_rdata > pair_max) ? rb_rdata : pair_max;
    assign rb_idx      = BW'(col_q >> 1);
    assign at_col_last = (col_q == COL_LAST);
    assign at_row_last = (row_q == ROW_LAST);
    assign discard     = (ODD_W && at_col_last) || (ODD_H && at_row_last);

    pool_row_buffer #(
        .DEPTH     (OUT_W),
        .DATA_WIDTH(DATA_WIDTH),
        .IW        (BW)
    ) u_rowbuf (
        .clk    (clk),
        .we_i   (rb_we),
        .widx_i (rb_idx),
        .wdata_i(pair_max),
        .ridx_i (rb_idx),
        .rdata_o(rb_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            pool_data_q  <= '0;
            pool_addr_q  <= '0;
            out_cnt_q    <= '0;
            pool_valid_q <= 1'b0;
            pool_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            pool_data_q  <= pool_data_d;
            pool_addr_q  <= pool_addr_d;
            out_cnt_q    <= out_cnt_d;
            pool_valid_q <= pool_valid_d;
            pool_done_q  <= pool_done_d;
        end
    end

    // Windows complete in raster order, so a running count equals row*OUT_W+col.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        pool_data_d  = pool_data_q;
        pool_addr_d  = pool_addr_q;
        out_cnt_d    = out_cnt_q;
        pool_valid_d = 1'b0;
        pool_done_d  = 1'b0;
        rb_we        = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d   = RUN;
                    col_d     = '0;
                    row_d     = '0;
                    out_cnt_d = '0;
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (!discard) begin
                        if (!col_q[0]) begin
                            hold_d = x;
                        end else if (!row_q[0]) begin
                            rb_we = 1'b1;
                        end else begin
                            pool_data_d  = win_max;
                            pool_addr_d  = out_cnt_q;
                            out_cnt_d    = out_cnt_q + 1'b1;
                            pool_valid_d = 1'b1;
                        end
                    end
                    if (at_col_last) begin
                        col_d = '0;
                        if (at_row_last) begin
                            state_d = DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DONE: begin
                pool_done_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pool_data  = pool_data_q;
    assign pool_addr  = pool_addr_q;
    assign pool_valid = pool_valid_q;
    assign pool_done  = pool_done_q;
    assign busy       = (state_q == RUN);

endmodule

// File: doc/maxpool2d.md
Name: maxpool2d

Overview:
- Downstream stage of the convolution engine.
- Consumes the raster-ordered feature-map sample stream, applies an optional ReLU, and performs 2x2 stride-2 max pooling.
- Emits each pooled value with its linear output address, then pulses a frame-done flag.
- Holds a single-row buffer of partial maxima; no full-frame storage.

Parameters:
- IN_WIDTH, 62, feature-map columns per row (≥2).
- IN_HEIGHT, 62, feature-map rows (≥2).
- DATA_WIDTH, 16, signed Q8.8 sample width.
- APPLY_RELU, 1, when 1 clamp negative samples to 0 before pooling.
- Derived (localparam): OUT_W = IN_WIDTH/2, OUT_H = IN_HEIGHT/2 (floor division).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- enable  input  1  arms the block for one frame.
- in_data  input  DATA_WIDTH  signed feature-map sample.
- in_valid  input  1  in_data is valid this cycle; one sample per high cycle.
- pool_data  output  DATA_WIDTH  pooled signed value.
- pool_addr  output  $clog2(OUT_W*OUT_H)  linear address, row*OUT_W+col.
- pool_valid  output  1  one-cycle strobe qualifying pool_data/pool_addr.
- pool_done  output  1  one-cycle strobe, frame complete.
- busy  output  1  high in RUN state.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low: sampled on clk rising edge when reset==0.
- Reset values: state=IDLE; col, row counters =0; pool_data=0; pool_addr=0; pool_valid=0; pool_done=0; busy=0; hold register=0. Row buffer contents need no reset.
- States:
  - IDLE: in_valid ignored. enable==1 -> RUN, counters cleared.
  - RUN: processes samples. Acceptance of sample (IN_HEIGHT-1, IN_WIDTH-1) -> DONE.
  - DONE: pool_done=1 for exactly one cycle -> IDLE. in_valid ignored.
- Sample pre-processing: x = (APPLY_RELU && in_data[MSB]) ? 0 : in_data. All comparisons are signed.
- Per accepted sample at (row r, col c):
  - c==IN_WIDTH-1 with IN_WIDTH odd, or r==IN_HEIGHT-1 with IN_HEIGHT odd: sample discarded. Counters still advance.
  - c even: hold <= x.
  - c odd, r even: rowbuf[c/2] <= max(hold, x).
  - c odd, r odd: pool_data <= max(rowbuf[c/2], hold, x); pool_addr <= (r/2)*OUT_W + c/2; pool_valid <= 1.
- Latency: pool_valid asserts the cycle after the bottom-right sample of a window is accepted. It is deasserted in every other cycle, including back-to-back input.
- Counters: col wraps IN_WIDTH-1 -> 0 and increments row. row does not wrap within a frame.
- Final window and done: for even dimensions, the final pool_valid and the DONE transition occur on the same edge. pool_done follows one cycle later.
- in_valid gaps of any length in RUN: no state change, outputs hold except pool_valid=0.
- enable deasserted mid-frame: no effect; the frame completes.
- Reset mid-frame: immediate return to reset values. Partial frame discarded, no pool_done.
- Width: max is pure compare/select, no arithmetic growth. pool_addr arithmetic is done at address width without truncation for legal parameters.

Decomposition:
- Shared package cnn_pkg:
  - DATA_WIDTH, Q8.8 FRAC_BITS=8.
  - function pooled_dim(n)=n/2.
  - state encoding IDLE/RUN/DONE (shared style with other CNN stages).
- Sub-module pool_row_buffer: OUT_W x DATA_WIDTH single-port register array with write enable, write index, read index. Combinational read; implementation may register it if latency is adjusted consistently.

Test Plan:
- 4x4, APPLY_RELU=1, samples 0..15 raster, back-to-back -> pool_valid 4 times: (addr0,5), (addr1,7), (addr2,13), (addr3,15). pool_done one cycle after the last strobe.
- 4x4, all samples 16'hFFFF (-1/256): APPLY_RELU=1 -> four outputs of 0. APPLY_RELU=0 -> four outputs of 16'hFFFF.
- 5x5, samples 0..24 -> outputs (0,6), (1,8), (2,16), (3,18). Samples 4, 9, 14, 19, 20..24 ignored. pool_done after the 25th sample, not after the 4th output.
- 4x4 with random 0-3 cycle in_valid gaps, mixed signs (e.g. window {-300, 200, 50, -1}) -> max 200 (16'h00C8), identical results to the gapless run.
- Reset asserted (reset=0) after 7 samples, then a new full 4x4 frame -> no stale outputs. Addresses restart at 0 with correct values. Exactly one pool_done.
- Defaults 62x62 ramp -> 961 pool_valid strobes, addresses 0..960 monotonic, pool_done once. in_valid pulses in IDLE/DONE produce no outputs.
